// File: rtl/ram_param_clr_if.sv
// ram_param_clr_if: bus bundle for the clearable parametrised RAM.
//   in       write data, driven by the master
//   load     write enable
//   address  read/write word address
//   clear    one-cycle request to zero every word
//   out      read data, driven by the RAM
//   busy     clear sweep in progress; writes are ignored while high
// Modports: master (the RAM user) and slave (the RAM itself).
interface ram_param_clr_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
);
  logic [WIDTH-1:0]  in;
  logic              load;
  logic [ADDR_W-1:0] address;
  logic              clear;
  logic [WIDTH-1:0]  out;
  logic              busy;

  modport master (output in, output load, output address, output clear,
                  input out, input busy);
  modport slave  (input in, input load, input address, input clear,
                  output out, output busy);
endinterface

// File: rtl/ram_param_clr.sv
// ram_param_clr: word-addressed RAM of 2**ADDR_W words x WIDTH bits with a
// hardware clear engine that zeroes every word, one per cycle, after reset or
// on a clear request.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; restarts the clear sweep at word 0
//   bus    ram_param_clr_if slave modport (in, load, address, clear, out, busy)
// Parameters:
//   WIDTH    data word width
//   ADDR_W   address width, DEPTH = 2**ADDR_W
//   REG_OUT  0: combinational read; 1: registered read with one cycle latency
module ram_param_clr #(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 3,
  parameter int REG_OUT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  ram_param_clr_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr, ptr_nx;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [WIDTH-1:0]  wd;
  logic              busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  // The sweep owns the single write port while busy, so user writes are
  // simply dropped rather than queued. Writes are suppressed on a reset edge.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    we       = 1'b0;
    wa       = bus.address;
    wd       = bus.in;
    case (state)
      CLEAR: begin
        we     = rst_n;
        wa     = ptr;
        wd     = '0;
        ptr_nx = ptr + ADDR_W'(1);
        if (ptr == LAST) state_nx = IDLE;
      end
      IDLE: begin
        // load and clear together: the write lands now, the sweep zeroes it later
        we = rst_n & bus.load;
        if (bus.clear) begin
          state_nx = CLEAR;
          ptr_nx   = '0;
        end
      end
      default: state_nx = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign busy     = (state == CLEAR);
  assign bus.busy = busy;

  generate
    if (REG_OUT != 0) begin : g_reg
      logic [WIDTH-1:0] rd_data_p1;

      // Read stage: samples pre-edge contents, so a same-edge write reads old data
      always_ff @(posedge clk) begin
        if (!rst_n) rd_data_p1 <= '0;
        else        rd_data_p1 <= busy ? '0 : mem[bus.address];
      end

      assign bus.out = rd_data_p1;
    end else begin : g_comb
      // Words not yet swept may hold garbage, so the read is masked while busy
      assign bus.out = busy ? '0 : mem[bus.address];
    end
  endgenerate

endmodule

// File: tb/tb_ram_param_clr.sv
// tb_ram_param_clr: scoreboard bench for ram_param_clr. Three instances:
//   A: WIDTH=16 ADDR_W=3 REG_OUT=0
//   B: WIDTH=16 ADDR_W=3 REG_OUT=1
//   C: WIDTH=8  ADDR_W=6 REG_OUT=0
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ram_param_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;

  ram_param_clr_if #(.WIDTH(16), .ADDR_W(3)) a_if ();
  ram_param_clr_if #(.WIDTH(16), .ADDR_W(3)) b_if ();
  ram_param_clr_if #(.WIDTH(8),  .ADDR_W(6)) c_if ();

  ram_param_clr #(.WIDTH(16), .ADDR_W(3), .REG_OUT(0)) u_a (
    .clk(clk), .rst_n(rst_a), .bus(a_if.slave));
  ram_param_clr #(.WIDTH(16), .ADDR_W(3), .REG_OUT(1)) u_b (
    .clk(clk), .rst_n(rst_b), .bus(b_if.slave));
  ram_param_clr #(.WIDTH(8),  .ADDR_W(6), .REG_OUT(0)) u_c (
    .clk(clk), .rst_n(rst_c), .bus(c_if.slave));

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem_m [3][64];
  int          sweep_m [3];
  int          ptr_m [3];
  int          depth [3]   = '{8, 8, 64};
  bit          reg_out [3] = '{1'b0, 1'b1, 1'b0};

  logic [31:0] exp_q [$];
  string       tag_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock edge of the reference RAM
  function automatic void model_step(input int d, input bit rst, input bit ld,
                                     input int ad, input logic [15:0] din, input bit cl);
    if (!rst) begin
      sweep_m[d] = depth[d];
      ptr_m[d]   = 0;
    end else if (sweep_m[d] > 0) begin
      mem_m[d][ptr_m[d]] = '0;
      ptr_m[d]++;
      sweep_m[d]--;
    end else begin
      if (ld) mem_m[d][ad] = din;
      if (cl) begin
        sweep_m[d] = depth[d];
        ptr_m[d]   = 0;
      end
    end
  endfunction

  task automatic drive(input int d, input bit rst, input bit ld, input int ad,
                       input logic [15:0] din, input bit cl);
    case (d)
      0: begin
        rst_a = rst; a_if.load = ld; a_if.address = 3'(ad); a_if.in = din; a_if.clear = cl;
      end
      1: begin
        rst_b = rst; b_if.load = ld; b_if.address = 3'(ad); b_if.in = din; b_if.clear = cl;
      end
      default: begin
        rst_c = rst; c_if.load = ld; c_if.address = 6'(ad); c_if.in = din[7:0]; c_if.clear = cl;
      end
    endcase
  endtask

  function automatic logic [31:0] get_out(input int d);
    case (d)
      0:       return {16'h0, a_if.out};
      1:       return {16'h0, b_if.out};
      default: return {24'h0, c_if.out};
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0:       return a_if.busy;
      1:       return b_if.busy;
      default: return c_if.busy;
    endcase
  endfunction

  // One cycle on DUT d; the other two sit idle and their models still advance.
  task automatic op(input int d, input bit rst, input bit ld, input int ad,
                    input logic [15:0] din, input bit cl, input bit rd, input string tag);
    if (d == 2) din &= 16'h00FF;
    for (int e = 0; e < 3; e++) begin
      if (e != d) begin
        drive(e, 1'b1, 1'b0, 0, 16'h0, 1'b0);
        model_step(e, 1'b1, 1'b0, 0, 16'h0, 1'b0);
      end
    end
    drive(d, rst, ld, ad, din, cl);
    if (rd && reg_out[d]) begin
      exp_q.push_back((!rst || sweep_m[d] > 0) ? 32'h0 : {16'h0, mem_m[d][ad]});
      tag_q.push_back(tag);
    end
    model_step(d, rst, ld, ad, din, cl);
    if (rd && !reg_out[d]) begin
      exp_q.push_back((sweep_m[d] > 0) ? 32'h0 : {16'h0, mem_m[d][ad]});
      tag_q.push_back(tag);
    end
    @(negedge clk);
    if (rd) chk(tag_q.pop_front(), get_out(d), exp_q.pop_front());
    chk({tag, "_busy"}, {31'h0, get_busy(d)}, {31'h0, sweep_m[d] > 0});
  endtask

  task automatic reset_all();
    for (int e = 0; e < 3; e++) begin
      drive(e, 1'b0, 1'b0, 0, 16'h0, 1'b0);
      model_step(e, 1'b0, 1'b0, 0, 16'h0, 1'b0);
    end
    @(negedge clk);
    for (int e = 0; e < 3; e++) begin
      chk("rst_busy", {31'h0, get_busy(e)}, 32'h1);
      chk("rst_out", get_out(e), 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    reset_all();

    // Reset sweep: busy for exactly 8 cycles, out held at zero
    for (int i = 0; i < 8; i++) op(0, 1, 0, 0, 16'h0, 0, 1, "t1_sweep_out");
    chk("t1_done_a", {31'h0, a_if.busy}, 32'h0);
    chk("t1_done_b", {31'h0, b_if.busy}, 32'h0);
    chk("t1_c_still_busy", {31'h0, c_if.busy}, 32'h1);
    for (int i = 0; i < 8; i++) op(0, 1, 0, i, 16'h0, 0, 1, "t1_zero");

    // Combinational write/read
    op(0, 1, 1, 5, 16'hBEEF, 0, 1, "t2_wr_rd");
    op(0, 1, 0, 4, 16'h0, 0, 1, "t2_addr4");
    op(0, 1, 0, 5, 16'h0, 0, 1, "t2_hold");

    // Registered read latency and read-old on same-edge write
    op(1, 1, 1, 3, 16'h1234, 0, 0, "t3_wr");
    op(1, 1, 0, 3, 16'h0, 0, 1, "t3_lat");
    op(1, 1, 1, 3, 16'h5678, 0, 1, "t3_old");
    op(1, 1, 0, 3, 16'h0, 0, 1, "t3_new");

    // Clear after fill; write during busy dropped
    for (int i = 0; i < 8; i++) op(0, 1, 1, i, 16'hFFFF, 0, 0, "t4_fill");
    for (int i = 0; i < 8; i++) op(0, 1, 0, i, 16'h0, 0, 1, "t4_full");
    cnt = 0;
    op(0, 1, 0, 0, 16'h0, 1, 1, "t4_clr");
    if (get_busy(0)) cnt++;
    op(0, 1, 1, 2, 16'hAAAA, 0, 1, "t4_drop");
    if (get_busy(0)) cnt++;
    for (int k = 0; k < 20 && get_busy(0); k++) begin
      op(0, 1, 0, 2, 16'h0, 0, 1, "t4_wait");
      if (get_busy(0)) cnt++;
    end
    chk("t4_len", cnt, 8);
    for (int i = 0; i < 8; i++) op(0, 1, 0, i, 16'h0, 0, 1, "t4_zero");

    // load and clear on the same edge: write happens, sweep then zeroes it
    op(0, 1, 1, 1, 16'h1111, 1, 1, "t4_ldclr");
    for (int k = 0; k < 20 && get_busy(0); k++) op(0, 1, 0, 1, 16'h0, 0, 1, "t4_ldclr_wait");
    op(0, 1, 0, 1, 16'h0, 0, 1, "t4_ldclr_zero");

    // Reset mid-sweep at ptr=4; clear during the sweep does not extend it
    op(0, 1, 1, 7, 16'h00C3, 0, 0, "t5_wr");
    op(0, 1, 0, 7, 16'h0, 1, 1, "t5_clr");
    for (int i = 0; i < 4; i++) op(0, 1, 0, 7, 16'h0, 0, 1, "t5_part");
    cnt = 0;
    op(0, 0, 0, 7, 16'h0, 0, 1, "t5_rst");
    if (get_busy(0)) cnt++;
    for (int k = 0; k < 20 && get_busy(0); k++) begin
      op(0, 1, 0, 7, 16'h0, k[0], 1, "t5_wait");
      if (get_busy(0)) cnt++;
    end
    chk("t5_len", cnt, 8);
    op(0, 1, 1, 7, 16'h5A5A, 0, 1, "t5_after");

    // Wide instance: 64-cycle sweep, then random traffic against the model
    cnt = 0;
    op(2, 0, 0, 0, 16'h0, 0, 1, "t6_rst");
    if (get_busy(2)) cnt++;
    for (int k = 0; k < 100 && get_busy(2); k++) begin
      op(2, 1, 1, k % 64, 16'h00FF, (k == 10), 1, "t6_wait");
      if (get_busy(2)) cnt++;
    end
    chk("t6_len", cnt, 64);
    for (int k = 0; k < 300; k++)
      op(2, 1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), 16'($urandom),
         ($urandom_range(0, 99) == 0), 1, "t6_rand");
    for (int k = 0; k < 100; k++)
      op(1, 1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 16'($urandom),
         ($urandom_range(0, 49) == 0), 1, "t6_rand_b");

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
